// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered read port, occupancy count and threshold flags.
// Storage is not reset; only pointers, count and the read/pulse outputs are.
module fifo_sync #(
    parameter int D_WIDTH  = 16,
    parameter int A_WIDTH  = 5,
    parameter int AF_LEVEL = 2**A_WIDTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] data_write,
    input  logic               write_enable,
    input  logic               read_enable,
    output logic [D_WIDTH-1:0] data_read,
    output logic               read_valid,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [A_WIDTH:0]   count,
    output logic               overflow,
    output logic               underflow
);

    localparam int DEPTH = 2**A_WIDTH;
    localparam int CNT_W = A_WIDTH + 1;

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [A_WIDTH-1:0] wr_ptr;
    logic [A_WIDTH-1:0] rd_ptr;
    logic               rd_accept;
    logic               wr_accept;

    assign full         = (count == CNT_W'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count <= CNT_W'(AE_LEVEL));

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign rd_accept = read_enable && !empty;
    assign wr_accept = write_enable && (!full || rd_accept);

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= data_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_read  <= '0;
            read_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // Reading the slot being written this edge returns the old word, never a bypass.
            if (rd_accept) begin
                rd_ptr    <= rd_ptr + 1'b1;
                data_read <= mem[rd_ptr];
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            read_valid <= rd_accept;
            overflow   <= write_enable && !wr_accept;
            underflow  <= read_enable && !rd_accept;
        end
    end

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: queue-based reference checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_fifo_sync;

    logic        clk;
    logic        rst;
    logic [15:0] data_write;
    logic        write_enable;
    logic        read_enable;
    logic [15:0] data_read;
    logic        read_valid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [5:0]  count;
    logic        overflow;
    logic        underflow;

    int vectors;
    int miscompares;
    bit chk_on;

    fifo_sync dut (
        .clk          (clk),
        .rst          (rst),
        .data_write   (data_write),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .data_read    (data_read),
        .read_valid   (read_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: a queue of stored words plus the registered outputs it implies.
    logic [15:0] q [$];
    logic [15:0] m_data;
    bit          m_valid;
    bit          m_ovf;
    bit          m_udf;
    bit          m_rd_ok;
    bit          m_wr_ok;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_data  = 16'h0000;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            m_rd_ok = read_enable && (q.size() > 0);
            m_wr_ok = write_enable && ((q.size() < 32) || m_rd_ok);
            m_valid = m_rd_ok;
            m_ovf   = write_enable && !m_wr_ok;
            m_udf   = read_enable && !m_rd_ok;
            if (m_rd_ok) m_data = q.pop_front();
            if (m_wr_ok) q.push_back(data_write);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("count",        32'(count),        32'(q.size()));
            chk("full",         32'(full),         32'(q.size() == 32));
            chk("empty",        32'(empty),        32'(q.size() == 0));
            chk("almost_full",  32'(almost_full),  32'(q.size() >= 30));
            chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
            chk("data_read",    32'(data_read),    32'(m_data));
            chk("read_valid",   32'(read_valid),   32'(m_valid));
            chk("overflow",     32'(overflow),     32'(m_ovf));
            chk("underflow",    32'(underflow),    32'(m_udf));
        end
    end

    // One clock with the given request; outputs are settled on return.
    task automatic cyc(input bit w, input bit r, input logic [15:0] d);
        write_enable = w;
        read_enable  = r;
        data_write   = d;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        chk_on       = 1'b0;
        rst          = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        data_write   = 16'h0000;
        #1 rst = 1'b1;
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",   32'(count),        32'd0);
        chk("rst_empty",   32'(empty),        32'd1);
        chk("rst_full",    32'(full),         32'd0);
        chk("rst_ae",      32'(almost_empty), 32'd1);
        chk("rst_af",      32'(almost_full),  32'd0);
        chk("rst_valid",   32'(read_valid),   32'd0);
        chk("rst_data",    32'(data_read),    32'd0);
        rst = 1'b0;

        // Three writes, three reads in order.
        for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 16'(i));
        chk("basic_count3", 32'(count), 32'd3);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b1, 16'h0);
            chk("basic_data",  32'(data_read),  32'(i));
            chk("basic_valid", 32'(read_valid), 32'd1);
        end
        chk("basic_empty", 32'(empty), 32'd1);
        chk("basic_count0", 32'(count), 32'd0);
        cyc(1'b0, 1'b0, 16'h0);
        chk("basic_valid_drop", 32'(read_valid), 32'd0);

        // Read on empty.
        cyc(1'b0, 1'b1, 16'h0);
        chk("udf_pulse", 32'(underflow),  32'd1);
        chk("udf_valid", 32'(read_valid), 32'd0);
        chk("udf_hold",  32'(data_read),  32'h0003);
        cyc(1'b0, 1'b0, 16'h0);
        chk("udf_clear", 32'(underflow),  32'd0);

        // Fill to full, then one rejected write.
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 1'b0, 16'h0100 + 16'(i));
            chk("fill_af", 32'(almost_full), 32'(i + 1 >= 30));
        end
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_count", 32'(count), 32'd32);
        cyc(1'b1, 1'b0, 16'hDEAD);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count),    32'd32);
        cyc(1'b0, 1'b0, 16'h0);
        chk("ovf_clear", 32'(overflow), 32'd0);
        for (int i = 0; i < 32; i++) begin
            cyc(1'b0, 1'b1, 16'h0);
            chk("drain_data", 32'(data_read), 32'h0100 + 32'(i));
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Full with simultaneous read and write.
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0, 16'h0200 + 16'(i));
        cyc(1'b1, 1'b1, 16'hBEEF);
        chk("rw_full_data",  32'(data_read), 32'h0200);
        chk("rw_full_count", 32'(count),     32'd32);
        chk("rw_full_ovf",   32'(overflow),  32'd0);
        for (int i = 1; i < 32; i++) begin
            cyc(1'b0, 1'b1, 16'h0);
            chk("rw_full_seq", 32'(data_read), 32'h0200 + 32'(i));
        end
        cyc(1'b0, 1'b1, 16'h0);
        chk("rw_full_beef", 32'(data_read), 32'hBEEF);
        chk("rw_full_empty", 32'(empty), 32'd1);

        // 40 writes interleaved with 40 reads, crossing the pointer wrap.
        cyc(1'b1, 1'b0, 16'h3000);
        for (int i = 1; i < 40; i++) begin
            cyc(1'b1, 1'b1, 16'h3000 + 16'(i));
            chk("wrap_data",  32'(data_read), 32'h3000 + 32'(i - 1));
            chk("wrap_flags", 32'({overflow, underflow}), 32'd0);
        end
        cyc(1'b0, 1'b1, 16'h0);
        chk("wrap_last", 32'(data_read), 32'h3027);
        chk("wrap_empty", 32'(empty), 32'd1);

        // Asynchronous reset between edges in the middle of a burst.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'h4000 + 16'(i));
        write_enable = 1'b1;
        read_enable  = 1'b1;
        data_write   = 16'h4444;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(count),      32'd0);
        chk("arst_empty", 32'(empty),      32'd1);
        chk("arst_valid", 32'(read_valid), 32'd0);
        chk("arst_data",  32'(data_read),  32'd0);
        write_enable = 1'b0;
        read_enable  = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1'b0, 1'b0, 16'h0);
        chk("arst_after", 32'(empty), 32'd1);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
